// File: rtl/seg_display_pkg.sv
// Shared types, constants and helpers for the seven-segment display driver.
// Leading-zero blanking in the top level is enabled by LEADING_ZERO_BLANK_EN.
package seg_display_pkg;

  localparam int BIN_W      = 10;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SHIFT_W    = BIN_W + BCD_W;
  localparam int ITER_W     = $clog2(BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } conv_state_t;

  // gfedcba, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: captures a 10-bit value on load and
// produces four BCD digits eleven cycles later, pulsing done on the update.
//
// state   | meaning
// IDLE    | waiting for load; display digits hold the last result
// CONVERT | ten shift-add-3 iterations over the shift register
// UPDATE  | copy BCD nibbles to the digit registers, pulse done
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t        state;
  logic [SHIFT_W-1:0] shreg;
  logic [ITER_W-1:0]  iter;
  logic [BCD_W-1:0]   adj;

  always_comb adj = add3(shreg[SHIFT_W-1:BIN_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= {{BCD_W{1'b0}}, value};
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          shreg <= {adj[BCD_W-2:0], shreg[BIN_W-1:0], 1'b0};
          iter  <= iter + 1'b1;
          if (iter == ITER_W'(BIN_W - 1)) state <= UPDATE;
        end
        UPDATE: begin
          bcd   <= shreg[SHIFT_W-1:BIN_W];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit common-anode display driver: converts the datapath result to BCD
// and scans it onto the display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  logic [BCD_W-1:0] bcd;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [3:0]       cur_digit;
  logic             blank;
  logic [6:0]       seg_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      2'd0: cur_digit = bcd[3:0];
      2'd1: cur_digit = bcd[7:4];
      2'd2: cur_digit = bcd[11:8];
      2'd3: cur_digit = bcd[15:12];
      default: cur_digit = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more significant digit are zero; digit 0 never is.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3: blank = (bcd[15:12] == 4'd0);
      2'd2: blank = (bcd[15:8] == 8'd0);
      2'd1: blank = (bcd[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? SEG_BLANK : seg_decode(cur_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a 4-cycle refresh divider.
module tb_seg_display_driver;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [9:0] value;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  logic [6:0] cap [4];

  seg_display_driver #(.REFRESH_DIV(4), .DIV_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .an    (an),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] digits, input int i);
    logic [15:0] upper;
    upper = digits >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && upper == 16'd0) return 7'b1111111;
`endif
    return seg_of(upper[3:0]);
  endfunction

  task automatic do_load(input logic [9:0] v);
    value = v;
    load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) cap[i] = 'x;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL first_scan_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL first_scan_seg got %b exp 1000000", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_scan();
    logic [3:0] e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      e = 4'b1111;
      e[(k / 4) % 4] = 1'b0;
      checks++;
      if (an !== e) begin errors++; $display("FAIL scan_an cycle %0d got %b exp %b", k, an, e); end
    end
  endtask

  task automatic test_max();
    int nb;
    do_load(10'd1023);
    nb = 0;
    while (busy === 1'b1 && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    checks++; if (nb != 11) begin errors++; $display("FAIL max_busy_cycles got %0d exp 11", nb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL max_done_pulse got %b exp 0", done); end
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp_seg(16'h1023, i)) begin
        errors++; $display("FAIL max_digit%0d got %b exp %b", i, cap[i], exp_seg(16'h1023, i));
      end
    end
  endtask

  task automatic test_ignore();
    bit ok;
    do_load(10'd30);
    repeat (4) @(negedge clk);
    value = 10'd999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b exp 1", busy); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_done timeout got 0 exp 1"); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_requeue busy got %b exp 0", busy); end
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp_seg(16'h0030, i)) begin
        errors++; $display("FAIL ignore_digit%0d got %b exp %b", i, cap[i], exp_seg(16'h0030, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_load(10'd512);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done timeout got 0 exp 1"); end
    value = 10'd7;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy got %b exp 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got %b exp 0", done); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done timeout got 0 exp 1"); end
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp_seg(16'h0007, i)) begin
        errors++; $display("FAIL b2b_digit%0d got %b exp %b", i, cap[i], exp_seg(16'h0007, i));
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    do_load(10'd858);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL abort_an got %b exp 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL abort_seg got %b exp 1111111", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp_seg(16'h0000, i)) begin
        errors++; $display("FAIL abort_cleared_digit%0d got %b exp %b", i, cap[i], exp_seg(16'h0000, i));
      end
    end
    do_load(10'd5);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reload_done timeout got 0 exp 1"); end
    capture();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== exp_seg(16'h0005, i)) begin
        errors++; $display("FAIL abort_reload_digit%0d got %b exp %b", i, cap[i], exp_seg(16'h0005, i));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    test_reset();
    test_scan();
    test_max();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
